lcd_fetch: RTL and testbench

// Screen fetch engine on the video side of blink.
// - Walks the screen base file (SBR) cell by cell and drives the video address bus va.
// - Reads each char/attr pair and its font byte back on vid_cdo.
// - Emits one attributed pixel byte per character cell to the LCD serializer downstream.
// - Uses only the memory slots blink leaves free for video (clkcnt != 2).

---
 rtl/lcd_fetch.sv | 230 +++++++++++++++++++++++
 tb/tb_lcd_fetch.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_fetch.sv
// lcd_fetch: screen fetch engine on the video side of blink.
// Walks the screen base file cell by cell, reads char, attribute and font
// byte over the video bus in the slots the Z80 leaves free, and hands one
// attributed pixel byte per cell to the LCD serializer.
module lcd_fetch #(
    parameter int COLS  = 106,
    parameter int TROWS = 8
) (
    input  logic        mck,
    input  logic        res,
    input  logic [1:0]  clkcnt,
    input  logic        lcdon,
    input  logic [12:0] pb0w,
    input  logic [9:0]  pb1w,
    input  logic [8:0]  pb2w,
    input  logic [10:0] pb3w,
    input  logic [10:0] sbrw,
    input  logic        t_1s,
    output logic [21:0] va,
    input  logic [7:0]  vid_cdo,
    output logic [7:0]  pix_data,
    output logic        pix_wide,
    output logic        pix_grey,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_valid,
    input  logic        pix_ready
);

    typedef enum logic [2:0] {IDLE, RD_CHR, RD_ATR, RD_FNT, EMIT} state_t;

    localparam logic [6:0] COL_LAST = 7'(COLS - 1);
    localparam logic [2:0] TL_LAST  = 3'(TROWS - 1);

    state_t      state, state_next;
    logic [2:0]  tl, pr;
    logic [6:0]  col;
    logic [12:0] pb0;
    logic [9:0]  pb1;
    logic [8:0]  pb2;
    logic [10:0] pb3;
    logic [10:0] sbr;
    logic [7:0]  chr;
    logic [5:0]  atr;
    logic [9:0]  idx_hi;
    logic [8:0]  idx_lo;
    logic [7:0]  pix_next;
    logic        slot_free, last_col, last_cell;
    logic        cap_chr, cap_atr, cap_pix, take, clear_cnt, load_shadow;

    // Clock phase 2 belongs to the Z80; any other phase completes a read.
    assign slot_free = (clkcnt != 2'd2);
    assign last_col  = (col == COL_LAST);
    assign last_cell = last_col && (pr == 3'd7) && (tl == TL_LAST);

    // The word and its sideband are only meaningful while EMIT holds them.
    assign pix_valid = (state == EMIT);
    assign pix_sof   = pix_valid && (tl == 3'd0) && (pr == 3'd0) && (col == 7'd0);
    assign pix_eol   = pix_valid && last_col;

    // State register.
    always_ff @(posedge mck or posedge res) begin
        // NOTE: every clocked assignment is non-blocking so all registers
        // update together from pre-edge values, independent of block order.
        if (res) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and per-cycle strobes; a dropped lcdon aborts any read.
    always_comb begin
        // NOTE: everything written here gets a default first, otherwise a
        // path that skips an assignment would infer a latch.
        state_next  = state;
        cap_chr     = 1'b0;
        cap_atr     = 1'b0;
        cap_pix     = 1'b0;
        take        = 1'b0;
        clear_cnt   = 1'b0;
        load_shadow = 1'b0;
        case (state)
            IDLE: begin
                if (lcdon) begin
                    state_next  = RD_CHR;
                    load_shadow = 1'b1;
                end
            end
            RD_CHR: begin
                if (!lcdon) begin
                    state_next = IDLE;
                    clear_cnt  = 1'b1;
                end else if (slot_free) begin
                    cap_chr    = 1'b1;
                    state_next = RD_ATR;
                end
            end
            RD_ATR: begin
                if (!lcdon) begin
                    state_next = IDLE;
                    clear_cnt  = 1'b1;
                end else if (slot_free) begin
                    cap_atr    = 1'b1;
                    state_next = RD_FNT;
                end
            end
            RD_FNT: begin
                if (!lcdon) begin
                    state_next = IDLE;
                    clear_cnt  = 1'b1;
                end else if (slot_free) begin
                    cap_pix    = 1'b1;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (pix_ready) begin
                    take = 1'b1;
                    if (!lcdon) begin
                        state_next = IDLE;
                        clear_cnt  = 1'b1;
                    end else begin
                        state_next  = RD_CHR;
                        load_shadow = last_cell;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Cell position: col fastest, then pixel row, then text line.
    always_ff @(posedge mck or posedge res) begin
        if (res) begin
            tl  <= '0;
            pr  <= '0;
            col <= '0;
        end else if (clear_cnt) begin
            tl  <= '0;
            pr  <= '0;
            col <= '0;
        end else if (take) begin
            if (last_col) begin
                col <= '0;
                if (pr == 3'd7) begin
                    pr <= '0;
                    tl <= (tl == TL_LAST) ? 3'd0 : tl + 3'd1;
                end else begin
                    pr <= pr + 3'd1;
                end
            end else begin
                col <= col + 7'd1;
            end
        end
    end

    // Base registers are frozen for a whole frame so a CPU update cannot tear it.
    always_ff @(posedge mck or posedge res) begin
        if (res) begin
            pb0 <= '0;
            pb1 <= '0;
            pb2 <= '0;
            pb3 <= '0;
            sbr <= '0;
        end else if (load_shadow) begin
            pb0 <= pb0w;
            pb1 <= pb1w;
            pb2 <= pb2w;
            pb3 <= pb3w;
            sbr <= sbrw;
        end
    end

    // Char and attribute captured as their reads complete.
    always_ff @(posedge mck or posedge res) begin
        if (res) begin
            chr <= '0;
            atr <= '0;
        end else begin
            if (cap_chr) chr <= vid_cdo;
            if (cap_atr) atr <= vid_cdo[5:0];
        end
    end

    // Attribute effects on the font byte; flash comes last and wins.
    always_comb begin
        pix_next = vid_cdo;
        if (!atr[5])
            pix_next = pix_next & 8'h3F;
        if (atr[1] && !atr[5] && (pr == 3'd7))
            pix_next = 8'h3F;
        if (atr[4])
            pix_next = pix_next ^ (atr[5] ? 8'hFF : 8'h3F);
        if (atr[3] && t_1s)
            pix_next = 8'h00;
    end

    // Output word register, loaded as the font read completes.
    always_ff @(posedge mck or posedge res) begin
        if (res) begin
            pix_data <= '0;
            pix_wide <= 1'b0;
            pix_grey <= 1'b0;
        end else if (cap_pix) begin
            pix_data <= pix_next;
            pix_wide <= atr[5];
            pix_grey <= atr[2];
        end
    end

    // Video address decode; upper char ranges select the alternate font bank.
    always_comb begin
        idx_hi = {atr[1:0], chr};
        idx_lo = {atr[0], chr};
        va     = '0;
        case (state)
            RD_CHR: va = {sbr, tl, col, 1'b0};
            RD_ATR: va = {sbr, tl, col, 1'b1};
            RD_FNT: begin
                if (atr[5]) begin
                    if (idx_hi >= 10'h300) va = {pb3, idx_hi[7:0], pr};
                    else                   va = {pb2, idx_hi, pr};
                end else begin
                    if (idx_lo >= 9'h1C0)  va = {pb0, idx_lo[5:0], pr};
                    else                   va = {pb1, idx_lo, pr};
                end
            end
            default: va = '0;
        endcase
    end

endmodule

// File: tb/tb_lcd_fetch.sv
// tb_lcd_fetch: directed bench for lcd_fetch with a scoreboard of expected
// pixel words and a small reference model of the cell walk.
module tb_lcd_fetch;

    localparam int COLS  = 106;
    localparam int TROWS = 8;

    typedef struct packed {
        logic [7:0] data;
        logic       wide;
        logic       grey;
        logic       sof;
        logic       eol;
    } word_t;

    logic        mck;
    logic        res;
    logic [1:0]  clkcnt;
    logic        lcdon;
    logic [12:0] pb0w;
    logic [9:0]  pb1w;
    logic [8:0]  pb2w;
    logic [10:0] pb3w;
    logic [10:0] sbrw;
    logic        t_1s;
    logic [21:0] va;
    logic [7:0]  vid_cdo;
    logic [7:0]  pix_data;
    logic        pix_wide;
    logic        pix_grey;
    logic        pix_sof;
    logic        pix_eol;
    logic        pix_valid;
    logic        pix_ready;

    lcd_fetch #(.COLS(COLS), .TROWS(TROWS)) dut (
        .mck       (mck),
        .res       (res),
        .clkcnt    (clkcnt),
        .lcdon     (lcdon),
        .pb0w      (pb0w),
        .pb1w      (pb1w),
        .pb2w      (pb2w),
        .pb3w      (pb3w),
        .sbrw      (sbrw),
        .t_1s      (t_1s),
        .va        (va),
        .vid_cdo   (vid_cdo),
        .pix_data  (pix_data),
        .pix_wide  (pix_wide),
        .pix_grey  (pix_grey),
        .pix_sof   (pix_sof),
        .pix_eol   (pix_eol),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready)
    );

    initial mck = 1'b0;
    always #5 mck = ~mck;

    // Video memory: explicit bytes override a fixed address hash.
    logic [7:0] mem [logic [21:0]];
    int         mem_ver = 0;

    function automatic logic [7:0] mem_rd(input logic [21:0] a);
        logic [7:0] h;
        if (mem.exists(a)) return mem[a];
        h = a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]};
        return h * 8'd29 + 8'd7;
    endfunction

    always @(va or mem_ver) vid_cdo = mem_rd(va);

    task automatic mem_wr(input logic [21:0] a, input logic [7:0] d);
        mem[a] = d;
        mem_ver++;
    endtask

    int    n_checks = 0;
    int    n_pass   = 0;
    int    sof_seen = 0;
    word_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model of position and frame-latched bases.
    int          m_tl, m_pr, m_col;
    logic [12:0] m_pb0;
    logic [9:0]  m_pb1;
    logic [8:0]  m_pb2;
    logic [10:0] m_pb3;
    logic [10:0] m_sbr;

    task automatic m_latch();
        m_pb0 = pb0w;
        m_pb1 = pb1w;
        m_pb2 = pb2w;
        m_pb3 = pb3w;
        m_sbr = sbrw;
    endtask

    task automatic m_reset();
        m_tl  = 0;
        m_pr  = 0;
        m_col = 0;
        m_latch();
    endtask

    task automatic m_advance();
        m_col++;
        if (m_col == COLS) begin
            m_col = 0;
            m_pr++;
            if (m_pr == 8) begin
                m_pr = 0;
                m_tl++;
                if (m_tl == TROWS) begin
                    m_tl = 0;
                    m_latch();
                end
            end
        end
    endtask

    function automatic logic [21:0] chr_addr(input int tl, input int col);
        return {m_sbr, 3'(tl), 7'(col), 1'b0};
    endfunction

    function automatic logic [21:0] font_addr(input logic [7:0] c, input logic [7:0] a, input logic [2:0] pr);
        logic [9:0] i10;
        logic [8:0] i9;
        i10 = {a[1:0], c};
        i9  = {a[0], c};
        if (a[5]) return (i10 >= 10'h300) ? {m_pb3, i10[7:0], pr} : {m_pb2, i10, pr};
        return (i9 >= 9'h1C0) ? {m_pb0, i9[5:0], pr} : {m_pb1, i9, pr};
    endfunction

    function automatic word_t model_word(input int tl, input int pr, input int col, input logic t1s);
        logic [21:0] ca;
        logic [7:0]  c, a, f;
        word_t       w;
        ca = chr_addr(tl, col);
        c  = mem_rd(ca);
        a  = mem_rd(ca | 22'd1);
        f  = mem_rd(font_addr(c, a, 3'(pr)));
        if (!a[5]) f = f & 8'h3F;
        if (a[1] && !a[5] && pr == 7) f = 8'h3F;
        if (a[4]) f = f ^ (a[5] ? 8'hFF : 8'h3F);
        if (a[3] && t1s) f = 8'h00;
        w.data = f;
        w.wide = a[5];
        w.grey = a[2];
        w.sof  = (tl == 0 && pr == 0 && col == 0);
        w.eol  = (col == COLS - 1);
        return w;
    endfunction

    function automatic word_t mk(input logic [7:0] d, input logic w, input logic s);
        return {d, w, 1'b0, s, 1'b0};
    endfunction

    function automatic word_t live_word();
        return {pix_data, pix_wide, pix_grey, pix_sof, pix_eol};
    endfunction

    task automatic push_const(input word_t w);
        sb.push_back(w);
        m_advance();
    endtask

    task automatic push_model(input logic t1s);
        sb.push_back(model_word(m_tl, m_pr, m_col, t1s));
        m_advance();
    endtask

    task automatic expect_va(input string tag, input logic [21:0] a);
        @(negedge mck);
        check(tag, 32'(va), 32'(a));
    endtask

    // Wait (bounded) for a word, compare against the scoreboard, optionally
    // hold it and drop lcdon, then accept it. Returns just after the edge.
    task automatic take_word(input string tag, input int hold, input logic drop);
        int    n;
        word_t exp, got;
        n = 0;
        @(negedge mck);
        while (pix_valid !== 1'b1 && n < 100) begin
            @(negedge mck);
            n++;
        end
        check({tag, "_valid"}, 32'(pix_valid), 32'd1);
        if (pix_valid !== 1'b1) return;
        exp = sb.pop_front();
        got = live_word();
        check({tag, "_word"}, 32'(got), 32'(exp));
        if (pix_sof === 1'b1) sof_seen++;
        if (drop) lcdon = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge mck);
            check({tag, "_hold"}, 32'({pix_valid, live_word()}), 32'({1'b1, got}));
        end
        pix_ready = 1'b1;
        @(posedge mck);
        #1 pix_ready = 1'b0;
    endtask

    initial begin
        int          n, ridx;
        logic        adv;
        logic [21:0] addr [3];

        res = 1'b1;  lcdon = 1'b0;  clkcnt = 2'd0;  t_1s = 1'b0;  pix_ready = 1'b0;
        pb0w = 13'h0ABC;  pb1w = 10'h001;  pb2w = 9'h002;  pb3w = 11'h5A5;  sbrw = 11'h001;

        mem_wr(22'h000800, 8'h41);  mem_wr(22'h000801, 8'h00);  mem_wr(22'h001208, 8'h3F);
        mem_wr(22'h000802, 8'h10);  mem_wr(22'h000803, 8'h20);  mem_wr(22'h004080, 8'hA5);
        mem_wr(22'h000804, 8'h20);  mem_wr(22'h000805, 8'h10);
        mem_wr(22'h000806, 8'h20);  mem_wr(22'h000807, 8'h08);
        mem_wr(22'h000808, 8'h20);  mem_wr(22'h000809, 8'h08);
        mem_wr(22'h00080A, 8'h20);  mem_wr(22'h00080B, 8'h02);
        mem_wr(22'h001100, 8'h0C);

        // Reset state.
        repeat (3) @(negedge mck);
        check("reset_va", 32'(va), 32'd0);
        check("reset_out", 32'({pix_data, pix_wide, pix_grey, pix_sof, pix_eol, pix_valid}), 32'd0);

        // Reset asserted while a word is pending.
        res = 1'b0;  lcdon = 1'b1;
        n = 0;
        while (pix_valid !== 1'b1 && n < 50) begin
            @(negedge mck);
            n++;
        end
        check("t1_reach_emit", 32'(pix_valid), 32'd1);
        res = 1'b1;
        #1 check("t1_reset_now", 32'({pix_valid, va, pix_data}), 32'd0);
        lcdon = 1'b0;
        @(negedge mck);
        check("t1_reset_next", 32'({pix_valid, va}), 32'd0);
        res = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge mck);
            check("t1_idle", 32'({pix_valid, va}), 32'd0);
        end

        // First cell: lores char 0x41 from the ROM font bank.
        lcdon = 1'b1;
        m_reset();
        push_const(mk(8'h3F, 1'b0, 1'b1));
        expect_va("t2_chr_va", 22'h000800);
        expect_va("t2_atr_va", 22'h000801);
        expect_va("t2_fnt_va", 22'h001208);
        take_word("t2", 0, 1'b0);

        // Hires cell from the RAM hires bank.
        push_const(mk(8'hA5, 1'b1, 1'b0));
        expect_va("t3_chr_va", 22'h000802);
        expect_va("t3_atr_va", 22'h000803);
        expect_va("t3_fnt_va", 22'h004080);
        take_word("t3", 0, 1'b0);

        // Reverse, then flash on and off.
        push_const(mk(8'h33, 1'b0, 1'b0));
        take_word("t4_reverse", 0, 1'b0);
        t_1s = 1'b1;
        push_const(mk(8'h00, 1'b0, 1'b0));
        take_word("t4_flash_on", 0, 1'b0);
        t_1s = 1'b0;
        push_const(mk(8'h0C, 1'b0, 1'b0));
        take_word("t4_flash_off", 0, 1'b0);

        // Z80 slots stall the reads: clkcnt cycles 2,0,1,2,...
        push_const(mk(8'h0C, 1'b0, 1'b0));
        addr[0] = 22'h00080A;  addr[1] = 22'h00080B;  addr[2] = 22'h001100;
        ridx = 0;
        clkcnt = 2'd2;
        for (int k = 0; k < 30 && ridx < 3; k++) begin
            adv = (clkcnt != 2'd2);
            @(negedge mck);
            if (adv) ridx++;
            if (ridx < 3) check("t5_slot_va", 32'(va), 32'(addr[ridx]));
            else          check("t5_slot_emit", 32'(pix_valid), 32'd1);
            clkcnt = (clkcnt == 2'd2) ? 2'd0 : clkcnt + 2'd1;
        end
        clkcnt = 2'd0;
        take_word("t5_slot", 0, 1'b0);

        // Back-pressure: word must hold steady for 10 cycles.
        push_model(1'b0);
        take_word("t5_hold", 10, 1'b0);

        // New bases mid-frame must only take effect at the wrap.
        sbrw = 11'h3FF;
        pb1w = 10'h2AA;
        for (int k = 0; k < COLS * 8 * TROWS && !(m_tl == 0 && m_pr == 0 && m_col == 0); k++) begin
            push_model(1'b0);
            take_word("frame", 0, 1'b0);
        end
        check("t6_one_sof", 32'(sof_seen), 32'd1);
        push_model(1'b0);
        take_word("t6_next_frame", 0, 1'b0);
        check("t6_sof_recur", 32'(sof_seen), 32'd2);

        // lcdon drop during the attribute read aborts without a word.
        expect_va("t6_chr_va", chr_addr(m_tl, m_col));
        expect_va("t6_atr_va", chr_addr(m_tl, m_col) | 22'd1);
        lcdon = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge mck);
            check("t6_abort", 32'({pix_valid, va}), 32'd0);
        end

        // Re-enable restarts at the frame origin; then drop lcdon during EMIT.
        lcdon = 1'b1;
        m_reset();
        push_model(1'b0);
        take_word("t6_restart", 3, 1'b1);
        check("t6_restart_sof", 32'(sof_seen), 32'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge mck);
            check("t6_emit_drop", 32'({pix_valid, va}), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
